pam_serial_rx: RTL
==================

Name: pam_serial_rx

Overview:
- Receive-side deserializer for the three-wire serial DAC link driven by the modulator in PAM mode (sdata, bclk, nsync).
- Oversamples the link with the system clock and recovers each DATA_LENGTH-bit word, MSB first.
- Presents recovered words on a one-entry valid/ready output port.
- Used for on-board loopback checking of the PAM path, and as a capture source for the unused FT245 TX direction.

Parameters:
- DATA_LENGTH, 24, bits per frame; legal range 2..32.
- CNT_WIDTH, 16, width of the received-frame counter.

Ports:
- clk  input  1  system clock (PLL output)
- rst  input  1  reset, synchronous, active-high
- sdata  input  1  serial data, asynchronous to clk
- bclk  input  1  bit clock, asynchronous; transmitter changes sdata on rising edge, receiver samples on falling edge
- nsync  input  1  frame strobe, active-low; a frame is the interval nsync=0
- word_o  output  DATA_LENGTH  recovered word; bit DATA_LENGTH-1 is the first bit received
- valid_o  output  1  word_o holds an unconsumed word
- ready_i  input  1  consumer accepts word_o when valid_o & ready_i at a clk edge
- busy_o  output  1  frame in progress
- short_frame_o  output  1  one-cycle pulse: frame ended with 1..DATA_LENGTH-1 bits
- overflow_o  output  1  sticky: a completed word was dropped
- clear_i  input  1  clears overflow_o
- frame_cnt_o  output  CNT_WIDTH  count of words delivered into the holding register; wraps modulo 2^CNT_WIDTH

Behaviour:
- Input synchronization and timing requirement:
  - sdata, bclk and nsync each pass through a 2-FF synchronizer followed by a 1-FF previous-value register.
  - All three paths have equal depth, so their relative timing is preserved.
  - Requirement: bclk high and low phases are each ≥2 clk periods; nominal bclk = clk/12.
  - Synchronizer and previous-value flops reset to 1.
- Edge detection:
  - Falling edge = previous 1, current 0 (synchronized values).
  - Rising edge = previous 0, current 1.
- Reset values: word_o=0, valid_o=0, busy_o=0, short_frame_o=0, overflow_o=0, frame_cnt_o=0, bit counter=0, FSM=IDLE.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on nsync falling edge; clear the bit counter and shift register.
    - If nsync is already low when reset releases, stay in IDLE until nsync goes high and then falls again.
  - SHIFT: on each bclk falling edge, shift synchronized sdata into the LSB and increment the counter.
    - When the counter reaches DATA_LENGTH, do the word load (below) and go to DONE.
  - SHIFT → IDLE on nsync rising edge when counter < DATA_LENGTH.
    - If counter ≥1, pulse short_frame_o for 1 cycle; no word is loaded.
    - If counter = 0, end silently.
  - DONE: ignore further bclk edges (extra bits are discarded); → IDLE on nsync rising edge, with no pulse.
  - busy_o = 1 in SHIFT and DONE.
- Word load (same clk edge as the final shift):
  - If the holding register is empty, or being consumed this cycle (valid_o & ready_i): word_o ← new word, valid_o ← 1, frame_cnt_o += 1.
  - Otherwise: new word dropped, word_o unchanged, overflow_o ← 1, frame_cnt_o unchanged.
- Consume without a load: valid_o & ready_i → valid_o ← 0; word_o retains its value.
- Latency: valid_o rises 3 clk cycles after the last bclk falling edge at the pin, ±1 cycle for synchronizer phase.
- overflow_o:
  - Cleared by clear_i.
  - If clear_i and a new overflow occur in the same cycle, the set wins.
- Simultaneous nsync rising edge and bclk falling edge in the same cycle: the bclk edge is processed first.
  - If it completes the word, the word loads and there is no short-frame pulse.
- Reset mid-frame: the partial word is discarded and all state returns to reset values.

Test Plan:
- Nominal frame: nsync low, 24 bits of 0xA5C3F0 at bclk=clk/12, ready_i=1 → valid_o high for exactly 1 cycle, word_o=0xA5C3F0, frame_cnt_o=1, short_frame_o never asserted.
- Short frame: 10 bits, then nsync high → one short_frame_o pulse, valid_o stays 0, frame_cnt_o unchanged. A following 0x000055 frame is received correctly.
- Overflow: ready_i=0, frames 0x000001 then 0xFFFFFE → word_o=0x000001, overflow_o=1, frame_cnt_o=1. Then pulse clear_i → overflow_o=0, word_o still 0x000001.
- Simultaneous accept and load: holding 0x111111 with valid_o=1; assert ready_i on the exact cycle frame 0x222222 completes → word_o=0x222222, valid_o stays 1, overflow_o=0, frame_cnt_o increments.
- Reset mid-frame after 12 bits of 0xFFFFFF → all outputs 0. Next full frame 0x123456 → word_o=0x123456, frame_cnt_o=1.
- Over-long frame: 28 bclk falling edges carrying 0xABCDEF followed by 0xF → word_o=0xABCDEF, no short_frame_o pulse, exactly 1 word delivered.

Source files
------------

// File: rtl/pam_serial_rx_if.sv
// Recovered-word output port of pam_serial_rx.
// The receiver drives the master side; a single-entry valid/ready handshake.
interface pam_serial_rx_if #(
    parameter int DATA_LENGTH = 24
);
    logic [DATA_LENGTH-1:0] word_o;
    logic                   valid_o;
    logic                   ready_i;

    modport master (output word_o, output valid_o, input ready_i);
    modport slave  (input word_o, input valid_o, output ready_i);
endinterface

// File: rtl/pam_serial_rx.sv
// Oversampling deserializer for the PAM serial DAC link (sdata/bclk/nsync).
// Recovers MSB-first words into a one-entry holding register with overflow and short-frame flags.
module pam_serial_rx #(
    parameter int DATA_LENGTH = 24,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sdata,
    input  logic                 bclk,
    input  logic                 nsync,
    pam_serial_rx_if.master      m_out,
    output logic                 busy_o,
    output logic                 short_frame_o,
    output logic                 overflow_o,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] frame_cnt_o
);
    localparam int BW = $clog2(DATA_LENGTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit order in the synchronizer vectors: {nsync, bclk, sdata}
    logic [2:0]             r_meta;
    logic [2:0]             r_sync;
    logic [2:0]             r_prev;
    logic [1:0]             r_fill;
    logic                   r_armed;
    state_t                 r_state;
    state_t                 w_next_state;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_LENGTH-2:0] r_shift;
    logic [DATA_LENGTH-1:0] r_word;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_short;
    logic                   r_overflow;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;

    logic                   w_sdata;
    logic                   w_bclk_fall;
    logic                   w_nsync_fall;
    logic                   w_nsync_rise;
    logic                   w_start;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_short;
    logic                   w_take;
    logic [DATA_LENGTH-1:0] w_new_word;

    // Two-stage synchronizers plus previous-value stage, equal depth on all three inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 3'b111;
            r_sync <= 3'b111;
            r_prev <= 3'b111;
        end else begin
            r_meta <= {nsync, bclk, sdata};
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Frame starts are only accepted once nsync has been seen high through a filled pipeline,
    // so a link already mid-frame at reset release is not mistaken for a new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill  <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
            if ((r_fill == 2'd3) && r_sync[2] && r_prev[2]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sdata      = r_prev[0];
    assign w_bclk_fall  = r_prev[1] & ~r_sync[1];
    assign w_nsync_fall = r_prev[2] & ~r_sync[2];
    assign w_nsync_rise = ~r_prev[2] & r_sync[2];
    assign w_new_word   = {r_shift, w_sdata};
    assign w_take       = r_valid & m_out.ready_i;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a completing bclk edge takes priority over nsync rising
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_nsync_fall && r_armed) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_bclk_fall && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = ST_DONE;
                end else if (w_nsync_rise) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (w_nsync_rise) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_start = (r_state == ST_IDLE) && w_nsync_fall && r_armed;
        w_shift = (r_state == ST_SHIFT) && w_bclk_fall;
        w_load  = w_shift && (r_bit_cnt == LAST_BIT);
        w_short = (r_state == ST_SHIFT) && w_nsync_rise && !w_load
                  && (w_bclk_fall || (r_bit_cnt != {BW{1'b0}}));
    end

    // Shift register, holding register, flags and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= {BW{1'b0}};
            r_shift     <= {(DATA_LENGTH-1){1'b0}};
            r_word      <= {DATA_LENGTH{1'b0}};
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_short     <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_start) begin
                r_bit_cnt <= {BW{1'b0}};
                r_shift   <= {(DATA_LENGTH-1){1'b0}};
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
                r_shift   <= w_new_word[DATA_LENGTH-2:0];
            end

            if (w_load && (!r_valid || m_out.ready_i)) begin
                r_word      <= w_new_word;
                r_valid     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            end else if (w_take) begin
                r_valid <= 1'b0;
            end

            if (w_load && r_valid && !m_out.ready_i) begin
                r_overflow <= 1'b1;
            end else if (clear_i) begin
                r_overflow <= 1'b0;
            end

            r_short <= w_short;
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    assign m_out.word_o  = r_word;
    assign m_out.valid_o = r_valid;
    assign busy_o        = r_busy;
    assign short_frame_o = r_short;
    assign overflow_o    = r_overflow;
    assign frame_cnt_o   = r_frame_cnt;
endmodule
